button_conditioner: RTL and testbench



---
 rtl/btn_cond_pkg.sv | 35 +++
 rtl/btn_debounce_ch.sv | 149 ++++++++++++++
 rtl/button_conditioner.sv | 39 +++
 tb/tb_button_conditioner.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// Shared definitions for the push-button conditioner.
// Holds the default timings for a 100 MHz clock, the board's channel indices
// and the auto-repeat state encoding. BTN_AUTOREPEAT_EN enables auto-repeat
// in the design files that import this package.
package btn_cond_pkg;

    // Default timings at 100 MHz.
    localparam int DEBOUNCE_10MS_100MHZ = 1_000_000;
    localparam int REPEAT_DELAY_400MS   = 40_000_000;
    localparam int REPEAT_PERIOD_150MS  = 15_000_000;

    // Channel order on the board (bit 0 is the centre button).
    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_R = 2;
    localparam int BTN_L = 3;
    localparam int BTN_D = 4;

    // Auto-repeat state per channel.
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Larger of two elaboration-time integers; sizes the hold counter.
    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One conditioner channel: optional input inversion, 2-FF synchroniser,
// stability-counter debounce, press/release edge pulses and, when
// BTN_AUTOREPEAT_EN is defined, the hold/auto-repeat state machine.
// The accepted level lives in stable_r; every output is a register fed
// from it, so nothing reaches the outputs combinationally from btn_in.
module btn_debounce_ch
    import btn_cond_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
    parameter int   REPEAT_DELAY    = REPEAT_DELAY_400MS,
    parameter int   REPEAT_PERIOD   = REPEAT_PERIOD_150MS,
    parameter logic INVERT          = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             raw_s;
    logic             sync_1_r;
    logic             sync_2_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;

    assign raw_s = btn_in ^ INVERT;

    // Two-flop synchroniser for the asynchronous pad input.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1_r <= 1'b0;
            sync_2_r <= 1'b0;
        end else begin
            sync_1_r <= raw_s;
            sync_2_r <= sync_1_r;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= 1'b0;
        end else if (sync_2_r == stable_r) begin
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= stable_r;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= sync_2_r;
        end else begin
            cnt_r    <= cnt_r + CNT_W'(1);
            stable_r <= stable_r;
        end
    end

    // Registered level and one-cycle edge pulses derived from the accepted level.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_level   <= stable_r;
            btn_press   <= stable_r & ~btn_level;
            btn_release <= ~stable_r & btn_level;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int              RC_MAX      = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int              RC_W        = $clog2(RC_MAX + 1);
    localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

    rpt_state_e      state_r;
    logic [RC_W-1:0] rc_r;
    logic            press_ev_s;
    logic            release_ev_s;

    // Same conditions that set btn_press / btn_release on this edge, so the
    // state machine moves in the very cycle the pulse appears.
    assign press_ev_s   = stable_r & ~btn_level;
    assign release_ev_s = ~stable_r & btn_level;

    // Hold timer: first pulse REPEAT_DELAY after press, then every REPEAT_PERIOD;
    // a release overrides any coincident repeat tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= RPT_IDLE;
            rc_r       <= {RC_W{1'b0}};
            btn_repeat <= 1'b0;
        end else if (release_ev_s) begin
            state_r    <= RPT_IDLE;
            rc_r       <= {RC_W{1'b0}};
            btn_repeat <= 1'b0;
        end else begin
            case (state_r)
                RPT_IDLE: begin
                    btn_repeat <= 1'b0;
                    rc_r       <= {RC_W{1'b0}};
                    if (press_ev_s) begin
                        state_r <= RPT_DELAY;
                    end else begin
                        state_r <= RPT_IDLE;
                    end
                end
                RPT_DELAY: begin
                    if (rc_r == DELAY_LAST) begin
                        btn_repeat <= 1'b1;
                        rc_r       <= {RC_W{1'b0}};
                        state_r    <= RPT_REPEAT;
                    end else begin
                        btn_repeat <= 1'b0;
                        rc_r       <= rc_r + RC_W'(1);
                        state_r    <= RPT_DELAY;
                    end
                end
                RPT_REPEAT: begin
                    if (rc_r == PERIOD_LAST) begin
                        btn_repeat <= 1'b1;
                        rc_r       <= {RC_W{1'b0}};
                    end else begin
                        btn_repeat <= 1'b0;
                        rc_r       <= rc_r + RC_W'(1);
                    end
                    state_r <= RPT_REPEAT;
                end
                default: begin
                    state_r    <= RPT_IDLE;
                    rc_r       <= {RC_W{1'b0}};
                    btn_repeat <= 1'b0;
                end
            endcase
        end
    end
`else
    // Repeat timings are irrelevant without auto-repeat; kept referenced only.
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;

    assign btn_repeat = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button / switch conditioner between the pads and game logic.
// Each channel is an independent btn_debounce_ch; there is no cross-channel
// priority. Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int                NUM_CH          = 5,
    parameter int                DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
    parameter int                REPEAT_DELAY    = REPEAT_DELAY_400MS,
    parameter int                REPEAT_PERIOD   = REPEAT_PERIOD_150MS,
    parameter logic [NUM_CH-1:0] INVERT_MASK     = {NUM_CH{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] btn_press,
    output logic [NUM_CH-1:0] btn_release,
    output logic [NUM_CH-1:0] btn_repeat
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .INVERT          (INVERT_MASK[i])
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .btn_in      (btn_in[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_repeat  (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DEBOUNCE=4, DELAY=10, PERIOD=3).
// Edge 0 is the first rising edge that samples a new input value; an accepted
// change shows on the outputs at edge 6. Repeat expectations follow
// BTN_AUTOREPEAT_EN.
module tb_button_conditioner;
    import btn_cond_pkg::*;

    localparam int NCH = 5;
    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR_EN = 1'b1;
`else
    localparam bit AR_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] btn_in = 5'b00000;
    logic [NCH-1:0] btn_level, btn_press, btn_release, btn_repeat;
    logic [NCH-1:0] btn_in_inv = 5'b00001;
    logic [NCH-1:0] level_inv, press_inv, release_inv, repeat_inv;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_CH(NCH), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .INVERT_MASK(5'b00000)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_repeat(btn_repeat)
    );

    button_conditioner #(
        .NUM_CH(NCH), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .INVERT_MASK(5'b00001)
    ) dut_inv (
        .clk(clk), .reset(reset), .btn_in(btn_in_inv),
        .btn_level(level_inv), .btn_press(press_inv),
        .btn_release(release_inv), .btn_repeat(repeat_inv)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run ncyc edges; channel ch changes to new_lvl at relative edge ev_at.
    // Repeat pulses expected at rep_first + k*RP while below rep_stop.
    task automatic window(input int ch, input int ncyc, input int ev_at, input logic new_lvl,
                          input int rep_first, input int rep_stop, input string tag);
        logic [NCH-1:0] m;
        logic [NCH-1:0] e_lvl, e_pr, e_rl, e_rp;
        m = 5'b00001 << ch;
        for (int n = 0; n < ncyc; n++) begin
            step();
            e_lvl = (((n >= ev_at) ? new_lvl : ~new_lvl) == 1'b1) ? m : 5'b00000;
            e_pr  = (new_lvl && n == ev_at) ? m : 5'b00000;
            e_rl  = (!new_lvl && n == ev_at) ? m : 5'b00000;
            e_rp  = (AR_EN && rep_first >= 0 && n >= rep_first && n < rep_stop &&
                     ((n - rep_first) % RP) == 0) ? m : 5'b00000;
            check_val($sformatf("%s_level@%0d", tag, n), btn_level, e_lvl);
            check_val($sformatf("%s_press@%0d", tag, n), btn_press, e_pr);
            check_val($sformatf("%s_release@%0d", tag, n), btn_release, e_rl);
            check_val($sformatf("%s_repeat@%0d", tag, n), btn_repeat, e_rp);
        end
    endtask

    initial begin
        // Reset state.
        reset = 1'b1;
        repeat (3) step();
        check_val("rst_level", btn_level, 5'b00000);
        check_val("rst_press", btn_press, 5'b00000);
        check_val("rst_release", btn_release, 5'b00000);
        check_val("rst_repeat", btn_repeat, 5'b00000);
        check_val("rst_inv_level", level_inv, 5'b00000);
        reset = 1'b0;

        // Idle: nothing moves.
        window(BTN_C, 8, 1000, 1'b1, -1, 0, "idle");

        // Clean press and quick release on BtnU (release before first repeat).
        btn_in[BTN_U] = 1'b1;
        window(BTN_U, 9, 6, 1'b1, -1, 0, "press");
        btn_in[BTN_U] = 1'b0;
        window(BTN_U, 9, 6, 1'b0, -1, 0, "release");

        // Bounce on BtnR: high 3, low 1, then steady high.
        for (int i = 0; i < 4; i++) begin
            btn_in[BTN_R] = (i < 3) ? 1'b1 : 1'b0;
            step();
            check_val($sformatf("bounce_level@%0d", i), btn_level, 5'b00000);
            check_val($sformatf("bounce_press@%0d", i), btn_press, 5'b00000);
        end
        btn_in[BTN_R] = 1'b1;
        window(BTN_R, 10, 6, 1'b1, -1, 0, "bounce");
        btn_in[BTN_R] = 1'b0;
        window(BTN_R, 9, 6, 1'b0, -1, 0, "bounce_rel");

        // Auto-repeat on BtnL: held 30 cycles after press, then released.
        btn_in[BTN_L] = 1'b1;
        window(BTN_L, 36, 6, 1'b1, 16, 36, "hold");
        btn_in[BTN_L] = 1'b0;
        window(BTN_L, 12, 6, 1'b0, 1, 6, "hold_rel");

        // Release lands on a repeat tick on BtnD: release wins, FSM idles.
        btn_in[BTN_D] = 1'b1;
        window(BTN_D, 16, 6, 1'b1, -1, 0, "coinc_hold");
        btn_in[BTN_D] = 1'b0;
        window(BTN_D, 15, 6, 1'b0, 0, 6, "coinc_rel");

        // Reset while BtnC is held in the repeat phase.
        btn_in[BTN_C] = 1'b1;
        window(BTN_C, 20, 6, 1'b1, 16, 20, "rst_hold");
        reset = 1'b1;
        step();
        check_val("rst_mid_level", btn_level, 5'b00000);
        check_val("rst_mid_press", btn_press, 5'b00000);
        check_val("rst_mid_release", btn_release, 5'b00000);
        check_val("rst_mid_repeat", btn_repeat, 5'b00000);
        reset = 1'b0;
        window(BTN_C, 18, 6, 1'b1, 16, 18, "rst_repress");
        btn_in[BTN_C] = 1'b0;
        window(BTN_C, 12, 6, 1'b0, 1, 6, "rst_rel");

        // Inverted channel: raw high all along means released.
        check_val("inv_level_held", level_inv, 5'b00000);
        check_val("inv_press_held", press_inv, 5'b00000);
        btn_in_inv[BTN_C] = 1'b0;
        for (int n = 0; n < 9; n++) begin
            step();
            check_val($sformatf("inv_level@%0d", n), level_inv, (n >= 6) ? 5'b00001 : 5'b00000);
            check_val($sformatf("inv_press@%0d", n), press_inv, (n == 6) ? 5'b00001 : 5'b00000);
            check_val($sformatf("inv_release@%0d", n), release_inv, 5'b00000);
            check_val($sformatf("inv_repeat@%0d", n), repeat_inv, 5'b00000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
